// File: rtl/param_updown_counter_if.sv
// ----------------------------------------------------------------------------
// param_updown_counter_if
// Bundles the control and status signals of param_updown_counter.
//
// Signals (WIDTH = count width):
//   en        count enable
//   dir       requested direction, 1 = up, 0 = down
//   step      increment magnitude per enabled cycle
//   load      synchronous parallel-load strobe
//   load_val  value to load
//   count     registered count value
//   tc        registered terminal-count pulse
//   dir_q     registered effective direction
//   at_max    combinational flag, count == MAX
//   at_min    combinational flag, count == 0
//
// Modports:
//   master  drives the controls, observes the status (the user of the counter)
//   slave   the counter itself
// ----------------------------------------------------------------------------
interface param_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             dir;
    logic [WIDTH-1:0] step;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             dir_q;
    logic             at_max;
    logic             at_min;

    modport master (
        output en, dir, step, load, load_val,
        input  count, tc, dir_q, at_max, at_min
    );

    modport slave (
        input  en, dir, step, load, load_val,
        output count, tc, dir_q, at_max, at_min
    );
endinterface

// File: rtl/param_updown_counter.sv
// ----------------------------------------------------------------------------
// param_updown_counter
// Parameterised up/down counter with selectable boundary behaviour:
//   MODE 0  wrap modulo MAX+1, tc when the update crosses a boundary
//   MODE 1  saturate at MAX / 0, tc whenever the new count sits on the
//           boundary in the travel direction
//   MODE 2  ping-pong: count along dir_q, clamp and reverse at the boundary
//
// Parameters:
//   WIDTH  count width in bits (2..16)
//   MAX    top count value (1..2**WIDTH-1)
//   MODE   boundary behaviour, see above
//
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset: count=0, tc=0, dir_q=1
//   bus    param_updown_counter_if.slave (en, dir, step, load, load_val in;
//          count, tc, dir_q, at_max, at_min out)
//
// Build option:
//   PARAM_UPDOWN_COUNTER_LOAD_EN  when defined, load/load_val perform a
//   synchronous load (count <= min(load_val, MAX)) with priority over en.
//   When undefined, load and load_val are ignored.
// ----------------------------------------------------------------------------
module param_updown_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = (1 << WIDTH) - 1,
    parameter int MODE  = 0
) (
    input logic                 clk,
    input logic                 rst,
    param_updown_counter_if.slave bus
);
    // One spare bit keeps count+step and count+MAX+1 from overflowing.
    localparam int W1 = WIDTH + 1;
    localparam logic [W1-1:0] MAX_X = W1'(MAX);
    localparam logic [W1-1:0] MOD_X = W1'(MAX + 1);

    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             dir_r;

    logic [W1-1:0] cnt_x;
    logic [W1-1:0] step_x;
    logic [W1-1:0] s_x;
    logic [W1-1:0] sum_x;
    logic [W1-1:0] nxt_x;
    logic          nxt_tc;
    logic          nxt_dir;
    logic          up;
    logic          load_hit;
    logic [W1-1:0] load_x;

`ifdef PARAM_UPDOWN_COUNTER_LOAD_EN
    assign load_hit = bus.load;
    assign load_x   = ({1'b0, bus.load_val} > MAX_X) ? MAX_X : {1'b0, bus.load_val};
`else
    assign load_hit = 1'b0;
    assign load_x   = '0;
    logic unused_load;
    assign unused_load = &{1'b0, bus.load, bus.load_val};
`endif

    // NOTE: every always_comb output gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        cnt_x   = {1'b0, count_r};
        step_x  = {1'b0, bus.step};
        s_x     = (step_x > MAX_X) ? MAX_X : step_x;
        sum_x   = cnt_x + s_x;
        up      = (MODE == 2) ? dir_r : bus.dir;
        nxt_x   = cnt_x;
        nxt_tc  = 1'b0;
        nxt_dir = (MODE == 2) ? dir_r : bus.dir;

        if (s_x == '0) begin
            // Zero effective step: everything holds, including direction.
            nxt_dir = dir_r;
        end else if (MODE == 0) begin
            if (up) begin
                if (sum_x > MAX_X) begin
                    nxt_x  = sum_x - MOD_X;
                    nxt_tc = 1'b1;
                end else begin
                    nxt_x = sum_x;
                end
            end else begin
                if (s_x > cnt_x) begin
                    nxt_x  = cnt_x + MOD_X - s_x;
                    nxt_tc = 1'b1;
                end else begin
                    nxt_x = cnt_x - s_x;
                end
            end
        end else begin
            // Saturate and ping-pong share the clamp; ping-pong also reverses.
            if (up) begin
                if (sum_x >= MAX_X) begin
                    nxt_x  = MAX_X;
                    nxt_tc = 1'b1;
                    if (MODE == 2) nxt_dir = 1'b0;
                end else begin
                    nxt_x = sum_x;
                end
            end else begin
                if (s_x >= cnt_x) begin
                    nxt_x  = '0;
                    nxt_tc = 1'b1;
                    if (MODE == 2) nxt_dir = 1'b1;
                end else begin
                    nxt_x = cnt_x - s_x;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            tc_r    <= 1'b0;
            dir_r   <= 1'b1;
        end else if (load_hit) begin
            count_r <= load_x[WIDTH-1:0];
            tc_r    <= 1'b0;
            dir_r   <= bus.dir;
        end else if (bus.en) begin
            count_r <= nxt_x[WIDTH-1:0];
            tc_r    <= nxt_tc;
            dir_r   <= nxt_dir;
        end else begin
            tc_r    <= 1'b0;
        end
    end

    assign bus.count  = count_r;
    assign bus.tc     = tc_r;
    assign bus.dir_q  = dir_r;
    assign bus.at_max = ({1'b0, count_r} == MAX_X);
    assign bus.at_min = (count_r == '0);
endmodule

// File: tb/tb_param_updown_counter.sv
// ----------------------------------------------------------------------------
// tb_param_updown_counter
// Four counter instances (all WIDTH=4):
//   0: MAX=15 MODE 0   1: MAX=9 MODE 0   2: MAX=15 MODE 1   3: MAX=5 MODE 2
// Stimulus pushes the expected {count, tc, dir_q, at_max, at_min} into a
// scoreboard queue; a monitor drains it on each falling edge (or on demand
// for the asynchronous-reset check) and compares against the addressed DUT.
// ----------------------------------------------------------------------------
module tb_param_updown_counter;
    typedef struct {
        int         dut;
        logic [3:0] count;
        logic       tc;
        logic       dir_q;
        string      name;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       en_v   [4];
    logic       dir_v  [4];
    logic [3:0] step_v [4];
    logic       load_v [4];
    logic [3:0] lv_v   [4];
    logic [3:0] cnt_o  [4];
    logic       tc_o   [4];
    logic       dq_o   [4];
    logic       amx_o  [4];
    logic       amn_o  [4];

    int max_of [4] = '{15, 9, 15, 5};

    param_updown_counter_if #(.WIDTH(4)) if0 ();
    param_updown_counter_if #(.WIDTH(4)) if1 ();
    param_updown_counter_if #(.WIDTH(4)) if2 ();
    param_updown_counter_if #(.WIDTH(4)) if3 ();

    param_updown_counter #(.WIDTH(4), .MAX(15), .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    param_updown_counter #(.WIDTH(4), .MAX(9),  .MODE(0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    param_updown_counter #(.WIDTH(4), .MAX(15), .MODE(1)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
    param_updown_counter #(.WIDTH(4), .MAX(5),  .MODE(2)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

    assign if0.en = en_v[0]; assign if0.dir = dir_v[0]; assign if0.step = step_v[0];
    assign if0.load = load_v[0]; assign if0.load_val = lv_v[0];
    assign if1.en = en_v[1]; assign if1.dir = dir_v[1]; assign if1.step = step_v[1];
    assign if1.load = load_v[1]; assign if1.load_val = lv_v[1];
    assign if2.en = en_v[2]; assign if2.dir = dir_v[2]; assign if2.step = step_v[2];
    assign if2.load = load_v[2]; assign if2.load_val = lv_v[2];
    assign if3.en = en_v[3]; assign if3.dir = dir_v[3]; assign if3.step = step_v[3];
    assign if3.load = load_v[3]; assign if3.load_val = lv_v[3];

    assign cnt_o[0] = if0.count; assign tc_o[0] = if0.tc; assign dq_o[0] = if0.dir_q;
    assign amx_o[0] = if0.at_max; assign amn_o[0] = if0.at_min;
    assign cnt_o[1] = if1.count; assign tc_o[1] = if1.tc; assign dq_o[1] = if1.dir_q;
    assign amx_o[1] = if1.at_max; assign amn_o[1] = if1.at_min;
    assign cnt_o[2] = if2.count; assign tc_o[2] = if2.tc; assign dq_o[2] = if2.dir_q;
    assign amx_o[2] = if2.at_max; assign amn_o[2] = if2.at_min;
    assign cnt_o[3] = if3.count; assign tc_o[3] = if3.tc; assign dq_o[3] = if3.dir_q;
    assign amx_o[3] = if3.at_max; assign amn_o[3] = if3.at_min;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got {count,tc,dir_q,at_max,at_min}=%b required %b", name, act, req);
    endtask

    // Monitor: drain every pending expectation against the addressed DUT.
    always @(negedge clk or sample_ev) begin
        while (sb.size() > 0) begin
            exp_t       e;
            logic [7:0] act;
            logic [7:0] req;
            e   = sb.pop_front();
            act = {cnt_o[e.dut], tc_o[e.dut], dq_o[e.dut], amx_o[e.dut], amn_o[e.dut]};
            req = {e.count, e.tc, e.dir_q,
                   (int'(e.count) == max_of[e.dut]), (e.count == 4'd0)};
            check(e.name, act, req);
        end
    end

    task automatic push(input int d, input logic [3:0] c, input logic t, input logic dq,
                        input string name);
        exp_t e;
        e.dut = d; e.count = c; e.tc = t; e.dir_q = dq; e.name = name;
        sb.push_back(e);
    endtask

    // One clock of stimulus on DUT d, then queue the expected post-edge state.
    task automatic cyc(input int d, input logic en, input logic dir, input logic [3:0] step,
                       input logic load, input logic [3:0] lv,
                       input logic [3:0] c, input logic t, input logic dq, input string name);
        en_v[d] = en; dir_v[d] = dir; step_v[d] = step; load_v[d] = load; lv_v[d] = lv;
        @(posedge clk);
        #1;
        push(d, c, t, dq, name);
        en_v[d] = 1'b0; load_v[d] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            en_v[i] = 1'b0; dir_v[i] = 1'b1; step_v[i] = 4'd0; load_v[i] = 1'b0; lv_v[i] = 4'd0;
        end
        // Reset held across an edge with en=1: must stay at reset values.
        en_v[0] = 1'b1; step_v[0] = 4'd1;
        #2;
        for (int i = 0; i < 4; i++) push(i, 4'd0, 1'b0, 1'b1, $sformatf("reset_dut%0d", i));
        #10;
        rst = 1'b0; en_v[0] = 1'b0;
        @(posedge clk);
        #1;

        // DUT0: MAX=15 wrap
        cyc(0, 1, 1, 4'd15, 0, 0, 4'd15, 0, 1, "d0_up15");
        cyc(0, 1, 1, 4'd1,  0, 0, 4'd0,  1, 1, "d0_wrap_up");
        cyc(0, 0, 1, 4'd1,  0, 0, 4'd0,  0, 1, "d0_en0_tc_low");
        cyc(0, 1, 0, 4'd2,  0, 0, 4'd14, 1, 0, "d0_wrap_down");
        cyc(0, 1, 1, 4'd0,  0, 0, 4'd14, 0, 0, "d0_step0_hold");
        cyc(0, 1, 0, 4'd7,  0, 0, 4'd7,  0, 0, "d0_down_to7");

        // DUT1: MAX=9 wrap, step clamp, load
        cyc(1, 1, 0, 4'd3,  0, 0, 4'd7, 1, 0, "d1_wrap_below0");
        cyc(1, 1, 0, 4'd3,  0, 0, 4'd4, 0, 0, "d1_down3");
        cyc(1, 1, 1, 4'd12, 0, 0, 4'd3, 1, 1, "d1_step_clamped");
`ifdef PARAM_UPDOWN_COUNTER_LOAD_EN
        cyc(1, 1, 1, 4'd1, 1, 4'd12, 4'd9, 0, 1, "d1_load_clamped");
        cyc(1, 1, 1, 4'd1, 0, 4'd0,  4'd0, 1, 1, "d1_after_load");
`else
        cyc(1, 1, 1, 4'd1, 1, 4'd12, 4'd4, 0, 1, "d1_load_ignored");
        cyc(1, 1, 1, 4'd1, 0, 4'd0,  4'd5, 0, 1, "d1_after_load");
`endif

        // DUT2: MAX=15 saturate
        cyc(2, 1, 1, 4'd14, 0, 0, 4'd14, 0, 1, "d2_up14");
        cyc(2, 1, 1, 4'd3,  0, 0, 4'd15, 1, 1, "d2_sat_max");
        cyc(2, 1, 1, 4'd3,  0, 0, 4'd15, 1, 1, "d2_hold_max");
        cyc(2, 0, 1, 4'd3,  0, 0, 4'd15, 0, 1, "d2_en0");
        cyc(2, 1, 0, 4'd15, 0, 0, 4'd0,  1, 0, "d2_sat_min");

        // DUT3: MAX=5 ping-pong, dir input ignored
        cyc(3, 1, 0, 4'd4,  0, 0, 4'd4, 0, 1, "d3_up4");
        cyc(3, 1, 1, 4'd3,  0, 0, 4'd5, 1, 0, "d3_hit_max");
        cyc(3, 1, 1, 4'd3,  0, 0, 4'd2, 0, 0, "d3_down3");
        cyc(3, 1, 1, 4'd3,  0, 0, 4'd0, 1, 1, "d3_hit_min");
        cyc(3, 1, 0, 4'd15, 0, 0, 4'd5, 1, 0, "d3_step_clamped");
        cyc(3, 0, 0, 4'd15, 0, 0, 4'd5, 0, 0, "d3_en0");

        // Asynchronous reset pulse between edges on DUT0 at count=7.
        @(negedge clk);
        en_v[0] = 1'b1; dir_v[0] = 1'b1; step_v[0] = 4'd3;
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        push(0, 4'd0, 1'b0, 1'b1, "d0_async_rst");
        -> sample_ev;
        #1;
        cyc(0, 1, 1, 4'd3, 0, 0, 4'd3, 0, 1, "d0_resume");

        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
